// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin share of one memory port between fetch and load/store.
// One transaction in flight; responses are routed back to the issuer, with an optional timeout.
module riscv_mem_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [XLEN-1:0]   d_req_addr,
  input  logic              d_req_we,
  input  logic [XLEN-1:0]   d_req_wdata,
  input  logic [XLEN/8-1:0] d_req_wstrb,
  output logic              d_rsp_valid,
  output logic [XLEN-1:0]   d_rsp_data,
  output logic              d_rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data
);
  localparam int SW = XLEN / 8;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic we_q, we_d, rsp_q, rsp_d, err_q, err_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pick_d;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      rsp_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end
  // owner/last_grant: 1 = load/store side; a tie goes to whoever did not win last
  assign pick_d = d_req_valid & (~if_req_valid | ~last_q);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    cnt_d   = cnt_q;
    rsp_d   = 1'b0;
    err_d   = 1'b0;
    data_d  = '0;
    case (state_q)
      IDLE: if (if_req_ready | d_req_ready) begin
        state_d = ISSUE;
        owner_d = pick_d;
        last_d  = pick_d;
        addr_d  = pick_d ? d_req_addr : if_req_addr;
        we_d    = pick_d & d_req_we;
        wdata_d = pick_d ? d_req_wdata : '0;
        wstrb_d = pick_d ? d_req_wstrb : '0;
      end
      ISSUE: if (mem_req_ready) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rsp_valid) begin
          state_d = IDLE;
          rsp_d   = 1'b1;
          data_d  = we_q ? '0 : mem_rsp_data;
        end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          rsp_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    if_req_ready  = state_q == IDLE && !resetn && if_req_valid && !pick_d;
    d_req_ready   = state_q == IDLE && !resetn && pick_d;
    mem_req_valid = state_q == ISSUE;
    mem_req_addr  = addr_q;
    mem_req_we    = we_q;
    mem_req_wdata = wdata_q;
    mem_req_wstrb = wstrb_q;
    if_rsp_valid  = rsp_q & ~owner_q;
    if_rsp_data   = owner_q ? '0 : data_q;
    if_rsp_err    = err_q & ~owner_q;
    d_rsp_valid   = rsp_q & owner_q;
    d_rsp_data    = owner_q ? data_q : '0;
    d_rsp_err     = err_q & owner_q;
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: table, directed and random checks of the memory arbiter with TIMEOUT=8.
module tb_riscv_mem_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0, resetn;
  logic if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [63:0] if_req_addr, if_rsp_data;
  logic d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
  logic [63:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [7:0] d_req_wstrb, mem_req_wstrb;
  logic mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  int total = 0, bad = 0;
  logic last_is_d;
  typedef struct {logic iv; logic dv; logic eir; logic edr;} vec_t;
  vec_t tv[4];

  riscv_mem_arbiter #(.XLEN(64), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mrv"}, 64'(mem_req_valid), 0);
    chk({tag, "_ird"}, 64'(if_req_ready), 0);
    chk({tag, "_drd"}, 64'(d_req_ready), 0);
    chk({tag, "_irv"}, 64'(if_rsp_valid), 0);
    chk({tag, "_drv"}, 64'(d_rsp_valid), 0);
  endtask

  // One full transaction: k stall cycles before mem accept, memory answers r cycles into WAIT.
  task automatic txn(input logic iv, input logic dv, input logic [63:0] ia, input logic [63:0] da,
                     input logic we, input logic [63:0] wd, input logic [7:0] ws,
                     input int k, input int r);
    logic w;
    logic [63:0] a;
    int p, n;
    w = (iv && dv) ? !last_is_d : dv;
    if_req_valid = iv; if_req_addr = ia;
    d_req_valid = dv; d_req_addr = da; d_req_we = we; d_req_wdata = wd; d_req_wstrb = ws;
    @(negedge clk);
    chk("if_req_ready", 64'(if_req_ready), 64'(!w));
    chk("d_req_ready", 64'(d_req_ready), 64'(w));
    last_is_d = w;
    a = w ? da : ia;
    step();
    if_req_valid = 0; d_req_valid = 0;
    for (int i = 0; i <= k; i++) begin
      mem_req_ready = (i == k);
      @(negedge clk);
      chk("mem_req_valid", 64'(mem_req_valid), 1);
      chk("mem_req_addr", mem_req_addr, a);
      chk("mem_req_we", 64'(mem_req_we), 64'(w && we));
      chk("mem_req_wdata", mem_req_wdata, w ? wd : 64'd0);
      chk("mem_req_wstrb", 64'(mem_req_wstrb), w ? 64'(ws) : 64'd0);
      chk("busy_ready", 64'(if_req_ready | d_req_ready), 0);
      step();
    end
    mem_req_ready = 0;
    p = (r <= TO - 1) ? r + 1 : TO;
    n = (p > r ? p : r) + 1;
    for (int j = 0; j <= n; j++) begin
      mem_rsp_valid = (j == r);
      mem_rsp_data = a + 1;
      @(negedge clk);
      chk("if_rsp_valid", 64'(if_rsp_valid), 64'(j == p && !w));
      chk("d_rsp_valid", 64'(d_rsp_valid), 64'(j == p && w));
      if (j < p) chk("wait_mrv", 64'(mem_req_valid), 0);
      if (j == p) begin
        chk("rsp_data", w ? d_rsp_data : if_rsp_data, (r <= TO - 1 && !(w && we)) ? a + 1 : 64'd0);
        chk("rsp_err", 64'(w ? d_rsp_err : if_rsp_err), 64'(r > TO - 1));
      end
      step();
    end
    mem_rsp_valid = 0;
  endtask

  initial begin
    tv[0] = '{0, 0, 0, 0};
    tv[1] = '{1, 0, 1, 0};
    tv[2] = '{0, 1, 0, 1};
    tv[3] = '{1, 1, 1, 0};
    resetn = 1;
    if_req_valid = 0; if_req_addr = 0;
    d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_req_wstrb = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    last_is_d = 1;
    repeat (3) begin
      step();
      chk_quiet("reset");
      chk("reset_addr", mem_req_addr, 0);
      chk("reset_wstrb", 64'(mem_req_wstrb), 0);
    end
    resetn = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      if_req_valid = tv[i].iv; d_req_valid = tv[i].dv;
      #2;
      chk("tbl_if_ready", 64'(if_req_ready), 64'(tv[i].eir));
      chk("tbl_d_ready", 64'(d_req_ready), 64'(tv[i].edr));
      #1;
      if_req_valid = 0; d_req_valid = 0;
      step();
    end
    txn(1, 0, 64'h1000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      txn(1, 1, 64'h2000 + 64'(i * 16), 64'h4000 + 64'(i * 16), 0, 0, 0, 0, 0);
    txn(0, 1, 0, 64'h80, 1, 64'hDEADBEEF, 8'h0F, 4, 0);
    txn(1, 0, 64'h1100, 0, 0, 0, 0, 0, 20);
    txn(0, 1, 0, 64'h1200, 0, 0, 0, 1, TO - 1);
    txn(0, 1, 0, 64'h1300, 1, 64'h55, 8'hF0, 0, TO);
    if_req_valid = 1; if_req_addr = 64'h3000;
    step();
    if_req_valid = 0;
    chk("pre_rst_mrv", 64'(mem_req_valid), 1);
    resetn = 1;
    #1;
    chk("async_mrv", 64'(mem_req_valid), 0);
    chk("async_addr", mem_req_addr, 0);
    step();
    resetn = 0;
    last_is_d = 1;
    if_req_valid = 1; if_req_addr = 64'h3100;
    step();
    if_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    resetn = 1;
    #1;
    chk_quiet("wait_rst");
    step();
    resetn = 0;
    last_is_d = 1;
    mem_rsp_valid = 1; mem_rsp_data = 64'h77;
    step();
    mem_rsp_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("post_rst");
      step();
    end
    txn(1, 1, 64'h3200, 64'h3300, 0, 0, 0, 0, 0);
    mem_req_ready = 1;
    for (int c = 0; c <= 9; c++) begin
      d_req_valid = (c % 3 == 0 && c < 9);
      d_req_addr = 64'h200 + 64'(8 * (c / 3));
      d_req_we = 0;
      mem_rsp_valid = (c % 3 == 2);
      mem_rsp_data = 64'h201 + 64'(8 * (c / 3));
      @(negedge clk);
      chk("b2b_d_ready", 64'(d_req_ready), 64'(c % 3 == 0 && c < 9));
      chk("b2b_d_rsp_valid", 64'(d_rsp_valid), 64'(c % 3 == 0 && c > 0));
      if (c % 3 == 0 && c > 0) chk("b2b_d_rsp_data", d_rsp_data, 64'h201 + 64'(8 * (c / 3 - 1)));
      step();
    end
    d_req_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    last_is_d = 1;
    for (int t = 0; t < 40; t++) begin
      logic iv, dv;
      iv = 1'($urandom);
      dv = 1'($urandom);
      if (!iv && !dv) iv = 1;
      txn(iv, dv, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom},
          8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 10)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares a single memory port between the core's instruction-fetch (IF) and load/store (D) requesters. The block arbitrates round-robin, latches the winning request, and issues it on the memory port. It tracks one outstanding transaction and routes the response back to the requester that issued it. A response timeout returns an error response if memory never answers. It sits between the riscv core's fetch and LSU stages and the memory/bus interface.

Parameters:
XLEN, 64, data/address width; must be a multiple of 8.
TIMEOUT, 1024, cycles spent in WAIT without mem_rsp_valid before an error response is returned; 0 disables the timeout.

Ports:
clk  in  1  clock; all state on rising edge.
resetn  in  1  asynchronous, active-high reset (resetn=1 holds the block in reset).
if_req_valid  in  1  fetch request.
if_req_ready  out  1  fetch request accepted this cycle.
if_req_addr  in  XLEN  fetch address.
if_rsp_valid  out  1  fetch response, one-cycle pulse.
if_rsp_data  out  XLEN  fetch read data.
if_rsp_err  out  1  fetch timed out; qualified by if_rsp_valid.
d_req_valid  in  1  data request.
d_req_ready  out  1  data request accepted this cycle.
d_req_addr  in  XLEN  data address.
d_req_we  in  1  1 = store.
d_req_wdata  in  XLEN  store data.
d_req_wstrb  in  XLEN/8  store byte enables.
d_rsp_valid  out  1  data response, one-cycle pulse (loads and stores).
d_rsp_data  out  XLEN  load data; 0 for stores.
d_rsp_err  out  1  data timed out; qualified by d_rsp_valid.
mem_req_valid  out  1  memory request valid.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  XLEN  latched address.
mem_req_we  out  1  latched write enable; always 0 for IF.
mem_req_wdata  out  XLEN  latched write data.
mem_req_wstrb  out  XLEN/8  latched byte enables; 0 for IF.
mem_rsp_valid  in  1  memory response (read data or write ack).
mem_rsp_data  in  XLEN  memory read data.

Behaviour:
- States: IDLE, ISSUE, WAIT. Registers: state, owner (IF/D), last_grant (IF/D), request latch, timeout counter, response outputs.
- Reset (asynchronous, resetn=1):
  - state=IDLE, last_grant=D, so the first tie goes to IF.
  - All outputs are 0 and all latches are cleared.
  - Any in-flight transaction is dropped; no response is produced for it.
- IDLE:
  - if_req_ready and d_req_ready are combinational and are never both 1.
  - Only IF valid: grant IF. Only D valid: grant D.
  - Both valid: grant the requester that is not last_grant.
  - On handshake (valid & ready): latch the request, set owner and last_grant, go to ISSUE.
  - Ready is 0 in every state other than IDLE.
- ISSUE:
  - mem_req_valid=1; mem_req_* are driven from the latch and stay stable until accepted.
  - On mem_req_ready: go to WAIT and clear the timeout counter.
  - mem_rsp_valid is ignored in ISSUE.
- WAIT:
  - mem_req_valid=0; the counter increments each cycle.
  - On mem_rsp_valid: next cycle assert <owner>_rsp_valid=1, set _rsp_data (D store: 0), _rsp_err=0, and go to IDLE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no response: next cycle assert <owner>_rsp_valid=1, _rsp_data=0, _rsp_err=1, and go to IDLE. A mem_rsp_valid arriving after the timeout is ignored.
  - mem_rsp_valid on the same cycle as the timeout expires wins: normal response, err=0.
- Response outputs are registered, valid for exactly one cycle, and return to 0 afterwards.
- In the cycle a response pulse is high, the state is IDLE, so a new request can be accepted that same cycle (back-to-back).
- Minimum latency, with mem_req_ready=1 and the response one cycle after acceptance: handshake at cycle T, mem_req_valid at T+1, mem_rsp_valid at T+2, rsp_valid at T+3.
- Exactly one transaction is outstanding at a time. The non-owner's rsp_valid never asserts.

Test Plan:
1. resetn held at 1 for 3 cycles, then 0, with all inputs idle -> all outputs 0 and state IDLE. if_req_valid=1, addr=0x1000 -> if_req_ready=1 the same cycle; mem_req_addr=0x1000 and we=0 the next cycle.
2. IF and D both valid, continuously, right after reset; memory responds 1 cycle after acceptance with data=addr+1 -> grants alternate IF, D, IF, D. Each rsp_data matches its own address+1, and no rsp_valid is seen on the wrong requester.
3. D store: addr=0x80, wdata=0xDEADBEEF, wstrb=0x0F; mem_req_ready held 0 for 4 cycles -> mem_req_* stable for all 4 cycles. After the ack, d_rsp_valid=1, d_rsp_data=0, d_rsp_err=0.
4. TIMEOUT=8, IF request accepted, memory never responds -> if_rsp_valid=1 with err=1 and data=0, exactly 9 cycles after mem_req_ready. A late mem_rsp_valid afterwards produces no pulse.
5. resetn asserted while in WAIT -> outputs 0 immediately (asynchronously). After release, a subsequent mem_rsp_valid yields no response and a new request is accepted normally.
6. Back-to-back D loads, 3 of them, with zero-wait memory -> a new d_req_ready in the same cycle as each d_rsp_valid; throughput of one transaction per 3 cycles.
